if_fetch_unit: RTL

- Instruction fetch stage and producer side of the IF/ID pipeline register.
- Holds the PC and issues in-order requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Pairs each returned instruction with its PC and presents both to the IF/ID register through a valid/ready handshake.
- Handles back-pressure from hazard stalls and discards fetches that are in flight when a branch or jump redirect occurs.

---
 rtl/if_fetch_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage and producer side of the IF/ID register
// Optional macro IF_FETCH_PERF_EN adds saturating perf_fetched/perf_dropped counters.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ifid_valid,
    input  logic        ifid_ready,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instruction
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [63:0]   pq_mem_q [DEPTH];
    logic [63:0]   pq_mem_d [DEPTH];
    logic [AW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;

    logic [63:0]   fifo_pc_q    [DEPTH];
    logic [63:0]   fifo_pc_d    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [AW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic credit_ok, req_fire, resp_keep, resp_drop, pop;

    always_comb begin
        // Credits cover both in-flight requests and buffered pairs, so the FIFO never overflows.
        credit_ok        = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < (CW+1)'(DEPTH);
        imem_req_valid   = reset && !redirect_valid && credit_ok;
        imem_req_addr    = pc_q;
        req_fire         = imem_req_valid && imem_req_ready;
        ifid_valid       = (fifo_cnt_q != '0);
        ifid_pc          = fifo_pc_q[fifo_rd_q];
        ifid_instruction = fifo_instr_q[fifo_rd_q];
        pop              = ifid_valid && ifid_ready;
        resp_keep        = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
        resp_drop        = imem_resp_valid && !resp_keep;
    end

    always_comb begin
        pc_d          = pc_q;
        pq_mem_d      = pq_mem_q;
        pq_wr_d       = pq_wr_q;
        pq_rd_d       = pq_rd_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

        if (req_fire) begin
            pq_mem_d[pq_wr_q] = pc_q;
            pq_wr_d           = pq_wr_q + 1'b1;
            pc_d              = pc_q + 64'd4;
        end

        if (resp_keep) begin
            fifo_pc_d[fifo_wr_q]    = pq_mem_q[pq_rd_q];
            fifo_instr_d[fifo_wr_q] = imem_resp_data;
            fifo_wr_d               = fifo_wr_q + 1'b1;
            pq_rd_d                 = pq_rd_q + 1'b1;
        end

        if (pop) begin
            fifo_rd_d = fifo_rd_q + 1'b1;
        end
        fifo_cnt_d = fifo_cnt_q + CW'(resp_keep) - CW'(pop);

        if (imem_resp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end

        // Every request still in flight after this edge belongs to the abandoned path.
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            pq_rd_d    = pq_wr_q;
            fifo_rd_d  = fifo_wr_q;
            fifo_cnt_d = '0;
            drop_cnt_d = outstanding_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            pq_wr_q       <= '0;
            pq_rd_q       <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pq_mem_q[i]     <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            pq_wr_q       <= pq_wr_d;
            pq_rd_q       <= pq_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
            pq_mem_q      <= pq_mem_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;
    logic [CW:0] drop_inc;
    logic [32:0] drop_sum;

    always_comb begin
        // A pair handed over in the redirect cycle is fetched, not flushed.
        drop_inc = {{CW{1'b0}}, resp_drop};
        if (redirect_valid) begin
            drop_inc = drop_inc + {1'b0, fifo_cnt_q} - {{CW{1'b0}}, pop};
        end
        drop_sum       = {1'b0, perf_dropped_q} + {{(32-CW){1'b0}}, drop_inc};
        perf_dropped_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        perf_fetched_d = perf_fetched_q;
        if (pop && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule
